irq_rr_arbiter: RTL
===================

// Module: irq_rr_arbiter
// PURPOSE
//  Upstream stage of the 8x3 encoder. Captures rising edges on N request lines into sticky pending bits.
//  Picks one eligible pending line per grant using round-robin priority.
//  Presents the winner as a strictly one-hot vector plus its binary index, over a valid/ready handshake.
//  Guarantees the downstream encoder never sees a zero or multi-hot input while gnt_valid=1.
// PARAMETERS
//  N      8   number of request lines (power of two, 2..32)
//  IDX_W  3   index width, = $clog2(N)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous reset, active-low
//  req_in       in   N      async-free level requests; rising edge = event
//  mask_in      in   N      1 = line ineligible for grant (pending still captured)
//  gnt_onehot   out  N      granted line, one-hot; all-zero when gnt_valid=0
//  gnt_idx      out  IDX_W  binary index of granted line; 0 when gnt_valid=0
//  gnt_valid    out  1      grant presented
//  gnt_ready    in   1      downstream accepts grant this cycle
//  pending      out  N      current pending register
//  overrun      out  N      sticky: edge arrived on a line already pending
//  overrun_clr  in   1      pulse; clears overrun register
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): req_q, pending, overrun, gnt_onehot, gnt_idx, gnt_valid, and ptr all go to 0; state=IDLE.
//  Edge detect: edge[i] = req_in[i] & ~req_q[i]; req_q <= req_in every cycle.
//  Pending: pending[i] <= (pending[i] & ~clr[i]) | edge[i], where clr = gnt_onehot when accepted.
//   An edge arriving in the same cycle as that line's acceptance leaves the bit set (set wins).
//  Overrun: overrun[i] sets when edge[i] & pending[i] & ~clr[i].
//   overrun_clr clears the register; a set in the same cycle wins.
//  Eligible = pending & ~mask_in & ~clr. The winner is the first eligible bit scanning from ptr upward, wrapping N-1 -> 0.
//  FSM:
//   IDLE: if |eligible, load winner into gnt_onehot/gnt_idx, set gnt_valid=1, go to HOLD.
//   HOLD: outputs frozen while gnt_ready=0; masking the held line does NOT revoke the grant.
//     On accept (gnt_valid & gnt_ready): clr = gnt_onehot; ptr <= (gnt_idx+1) mod N.
//     If eligible (computed with ptr already advanced, excluding the accepted line) is non-zero, load the next winner
//     the same cycle and stay in HOLD (back-to-back, 1 grant/cycle). Otherwise clear the outputs and go to IDLE.
//  Latency: req_in rises before edge t -> pending set at t -> gnt_valid at t+1 if IDLE and unmasked.
//  A masked line becomes eligible the cycle after mask_in drops.
//  ptr only moves on acceptance. The wrap from N-1 to 0 is modular; IDX_W arithmetic truncates.
//  Reset mid-handshake discards the grant and all pending events; nothing is re-presented after reset.
//  Invariant: gnt_valid=1 implies $onehot(gnt_onehot) and gnt_onehot == 1<<gnt_idx.
// STRUCTURE
//  Package irq_arb_pkg: N, IDX_W defaults; state enum {IDLE, HOLD}.
//  Sub-module rr_pick (combinational): inputs eligible[N], ptr[IDX_W]; outputs win_onehot[N], win_idx[IDX_W], win_any.
//   Implemented as a double-width rotate-and-priority-scan.
//  Top level: edge-detect registers, pending/overrun registers, FSM, ptr register, output registers.
// TESTING
//  1. Reset then single request: req_in=8'h04 rising at cycle 2, ready=1
//     -> gnt_valid@3, gnt_onehot=8'h04, gnt_idx=2; pending=0 @4; ptr=3.
//  2. Round-robin: ptr=0, req_in 8'h00->8'h81 together, ready=1
//     -> grants idx 0 then idx 7 on consecutive cycles; next simultaneous 8'h81 event (ptr=0 after wrap) -> 0 first again.
//  3. Backpressure: grant idx 5 held with ready=0 for 4 cycles while line 1 rises
//     -> gnt_onehot stays 8'h20 and gnt_idx stays 5; after ready=1, idx 1 granted next cycle.
//  4. Set-wins / overrun: re-pulse line 3 in its acceptance cycle -> pending[3] stays 1, overrun[3]=0.
//     Pulse it again before acceptance -> overrun[3]=1 until overrun_clr.
//  5. Mask: pending=8'h0C, mask_in=8'h04 -> only idx 3 granted; drop mask -> idx 2 granted next cycle.
//  6. Reset mid-HOLD: rst_n=0 for one cycle while gnt_valid=1, pending=8'hF0 -> all outputs 0; no grant after release.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared defaults and FSM state type for the round-robin interrupt arbiter.
package irq_arb_pkg;

  localparam int unsigned NDefault    = 8;
  localparam int unsigned IdxWDefault = $clog2(NDefault);

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    // Rotate so ptr lands at bit 0, then the lowest set bit is the winner's offset.
    dbl = {eligible, eligible} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    win_any    = |eligible;
    win_idx    = win_any ? ptr + off : '0;
    win_onehot = win_any ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/irq_rr_arbiter.sv
// Edge-capturing interrupt arbiter: sticky pending bits, round-robin one-hot grant over valid/ready.
module irq_rr_arbiter
  import irq_arb_pkg::*;
#(
  parameter int unsigned N     = NDefault,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask_in,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overrun,
  input  logic             overrun_clr
);

  state_e           state_q, state_d;
  logic [N-1:0]     req_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     overrun_q, overrun_d;
  logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             accept;
  logic [N-1:0]     clr;
  logic [N-1:0]     rise;
  logic [N-1:0]     eligible;
  logic [N-1:0]     win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  always_comb begin
    accept    = gnt_valid_q & gnt_ready;
    clr       = accept ? gnt_onehot_q : '0;
    rise      = req_in & ~req_q;
    // The accepted line is excluded so it cannot be re-granted in its own accept cycle.
    eligible  = pending_q & ~mask_in & ~clr;
    ptr_d     = accept ? gnt_idx_q + IDX_W'(1) : ptr_q;
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = (overrun_clr ? '0 : overrun_q) | (rise & pending_q & ~clr);
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible   (eligible),
    .ptr        (ptr_d),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  always_comb begin
    state_d      = state_q;
    gnt_onehot_d = gnt_onehot_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          gnt_onehot_d = win_onehot;
          gnt_idx_d    = win_idx;
          gnt_valid_d  = 1'b1;
          state_d      = StHold;
        end
      end
      StHold: begin
        // Outputs stay frozen until accepted; masking the held line does not revoke it.
        if (accept) begin
          if (win_any) begin
            gnt_onehot_d = win_onehot;
            gnt_idx_d    = win_idx;
            gnt_valid_d  = 1'b1;
          end else begin
            gnt_onehot_d = '0;
            gnt_idx_d    = '0;
            gnt_valid_d  = 1'b0;
            state_d      = StIdle;
          end
        end
      end
      default: begin
        gnt_onehot_d = '0;
        gnt_idx_d    = '0;
        gnt_valid_d  = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_q        <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_in;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign gnt_onehot = gnt_onehot_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_valid  = gnt_valid_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule
